// File: rtl/exc_sequencer.sv
// Exception/interrupt sequencer in front of CP0: prioritises sources, pulses the
// interrupt code, writes EPC, drains the pipeline and redirects to the handler.
module exc_sequencer #(
   parameter int FLUSH_CYCLES = 2,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ExtIrq,
   input  logic        IllInst,
   input  logic        Overflow,
   input  logic        Eret,
   input  logic        InstValid,
   input  logic [31:0] ExcPc,
   input  logic [31:0] StatusData,
   input  logic [31:0] EpcData,
   input  logic [31:0] InterruptPc,
   input  logic        MtcWe,
   input  logic [4:0]  MtcAddr,
   input  logic [31:0] MtcData,
   output logic [1:0]  Interrupt,
   output logic        CpWe,
   output logic [4:0]  CpWAddr,
   output logic [31:0] CpWData,
   output logic        Flush,
   output logic        Stall,
   output logic        PcRedirect,
   output logic [31:0] RedirectPc,
   output logic        Busy
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LATCH    = 3'd1;
   localparam logic [2:0] S_FLUSH    = 3'd2;
   localparam logic [2:0] S_REDIRECT = 3'd3;
   localparam logic [2:0] S_ERET     = 3'd4;

   localparam logic [3:0] CNT_LAST   = 4'(FLUSH_CYCLES - 1);
   localparam logic [4:0] ADDR_STAT  = 5'd12;
   localparam logic [4:0] ADDR_EPC   = 5'd14;

   logic [2:0]             state_reg, state_next;
   logic [SYNC_STAGES-1:0] sync_reg;
   logic [1:0]             code_reg;
   logic [31:0]            pc_reg;
   logic [31:0]            vec_reg;
   logic                   keep_reg;
   logic [3:0]             cnt_reg;

   logic        ext_sync;
   logic        ie, exl;
   logic        exc_take, eret_take;
   logic [1:0]  exc_code;

   logic [1:0]  int_c;
   logic        we_c, flush_c, stall_c, redir_c;
   logic [4:0]  waddr_c;
   logic [31:0] wdata_c, rpc_c;

   assign ext_sync = sync_reg[SYNC_STAGES-1];
   assign ie       = StatusData[0];
   assign exl      = StatusData[1];

   always_comb begin
      exc_code = 2'b00;
      if (IllInst)
         exc_code = 2'b10;
      else if (Overflow)
         exc_code = 2'b11;
      else if (ext_sync && ie && !exl)
         exc_code = 2'b01;
   end

   assign exc_take  = InstValid && (exc_code != 2'b00);
   assign eret_take = InstValid && Eret;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= S_IDLE;
         sync_reg  <= '0;
         code_reg  <= 2'b00;
         pc_reg    <= '0;
         vec_reg   <= '0;
         keep_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         sync_reg  <= {sync_reg[SYNC_STAGES-2:0], ExtIrq};
         case (state_reg)
            S_IDLE: begin
               if (exc_take) begin
                  code_reg <= exc_code;
                  pc_reg   <= ExcPc;
                  keep_reg <= exl;
               end
            end
            // CP0 presents the handler vector only while Interrupt is driven.
            S_LATCH: begin
               vec_reg <= InterruptPc;
               cnt_reg <= '0;
            end
            S_FLUSH:  cnt_reg <= cnt_reg + 4'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state_reg;
      int_c      = 2'b00;
      we_c       = 1'b0;
      waddr_c    = '0;
      wdata_c    = '0;
      flush_c    = 1'b0;
      stall_c    = 1'b0;
      redir_c    = 1'b0;
      rpc_c      = '0;
      case (state_reg)
         S_IDLE: begin
            we_c    = MtcWe;
            waddr_c = MtcAddr;
            wdata_c = MtcData;
            if (exc_take)
               state_next = S_LATCH;
            else if (eret_take)
               state_next = S_ERET;
         end
         S_LATCH: begin
            int_c      = code_reg;
            stall_c    = 1'b1;
            state_next = S_FLUSH;
         end
         S_FLUSH: begin
            stall_c = 1'b1;
            flush_c = 1'b1;
            // A nested exception must not overwrite the outer EPC.
            if (cnt_reg == 4'd0) begin
               we_c    = !keep_reg;
               waddr_c = ADDR_EPC;
               wdata_c = pc_reg;
            end
            if (cnt_reg == CNT_LAST)
               state_next = S_REDIRECT;
         end
         S_REDIRECT: begin
            redir_c    = 1'b1;
            rpc_c      = vec_reg;
            state_next = S_IDLE;
         end
         S_ERET: begin
            we_c       = 1'b1;
            waddr_c    = ADDR_STAT;
            wdata_c    = StatusData & ~32'h2;
            redir_c    = 1'b1;
            rpc_c      = EpcData;
            flush_c    = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs are forced low for the whole reset interval, including the MTC0 bypass.
   assign Interrupt  = int_c   & {2{rst}};
   assign CpWe       = we_c    & rst;
   assign CpWAddr    = waddr_c & {5{rst}};
   assign CpWData    = wdata_c & {32{rst}};
   assign Flush      = flush_c & rst;
   assign Stall      = stall_c & rst;
   assign PcRedirect = redir_c & rst;
   assign RedirectPc = rpc_c   & {32{rst}};
   assign Busy       = rst && (state_reg != S_IDLE);

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: expected per-cycle output timelines are built from the
// latency rules and compared at the falling edge.
module tb_exc_sequencer;

   localparam int F = 2;
   localparam int S = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        ExtIrq, IllInst, Overflow, Eret, InstValid;
   logic [31:0] ExcPc, StatusData, EpcData, InterruptPc;
   logic        MtcWe;
   logic [4:0]  MtcAddr;
   logic [31:0] MtcData;
   logic [1:0]  Interrupt;
   logic        CpWe, Flush, Stall, PcRedirect, Busy;
   logic [4:0]  CpWAddr;
   logic [31:0] CpWData, RedirectPc;

   int errors = 0;
   int checks = 0;

   logic [75:0] exp_q[$];
   logic [75:0] msk_q[$];
   logic [75:0] obs, e, m;

   exc_sequencer #(.FLUSH_CYCLES(F), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .ExtIrq(ExtIrq), .IllInst(IllInst), .Overflow(Overflow),
      .Eret(Eret), .InstValid(InstValid), .ExcPc(ExcPc), .StatusData(StatusData),
      .EpcData(EpcData), .InterruptPc(InterruptPc), .MtcWe(MtcWe), .MtcAddr(MtcAddr),
      .MtcData(MtcData), .Interrupt(Interrupt), .CpWe(CpWe), .CpWAddr(CpWAddr),
      .CpWData(CpWData), .Flush(Flush), .Stall(Stall), .PcRedirect(PcRedirect),
      .RedirectPc(RedirectPc), .Busy(Busy)
   );

   always #5 clk = ~clk;

   // CP0 stand-in: handler vector by cause
   assign InterruptPc = (Interrupt == 2'b01) ? 32'h18 :
                        (Interrupt == 2'b10) ? 32'h4  :
                        (Interrupt == 2'b11) ? 32'h10 : 32'h0;

   assign obs = {Interrupt, CpWe, CpWAddr, CpWData, Flush, Stall, PcRedirect, RedirectPc, Busy};

   function automatic logic [75:0] mk(input logic [1:0] i, input logic we, input logic [4:0] a,
                                      input logic [31:0] d, input logic fl, input logic st,
                                      input logic rd, input logic [31:0] rp, input logic b);
      return {i, we, a, d, fl, st, rd, rp, b};
   endfunction

   // Write address/data matter only with CpWe, RedirectPc only with PcRedirect
   function automatic logic [75:0] mkmask(input logic we, input logic rd);
      return {3'b111, {37{we}}, 3'b111, {32{rd}}, 1'b1};
   endfunction

   function automatic logic [31:0] vec_of(input logic [1:0] c);
      return (c == 2'b01) ? 32'h18 : (c == 2'b10) ? 32'h4 : 32'h10;
   endfunction

   // Exception taken at edge T: code at T+1, EPC write T+2, flush T+2..T+1+F, redirect T+2+F, idle after
   task automatic push_exc(input logic [1:0] code, input logic [31:0] pc, input logic keep);
      exp_q.push_back(mk(code, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1));
      msk_q.push_back(mkmask(1'b0, 1'b0));
      for (int k = 0; k < F; k++) begin
         exp_q.push_back(mk(2'b00, (k == 0) && !keep, 5'd14, pc, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1));
         msk_q.push_back(mkmask((k == 0) && !keep, 1'b0));
      end
      exp_q.push_back(mk(2'b00, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, vec_of(code), 1'b1));
      msk_q.push_back(mkmask(1'b0, 1'b1));
      exp_q.push_back('0);
      msk_q.push_back(mkmask(1'b0, 1'b0));
   endtask

   task automatic push_eret(input logic [31:0] st, input logic [31:0] epc);
      exp_q.push_back(mk(2'b00, 1'b1, 5'd12, st & ~32'h2, 1'b1, 1'b0, 1'b1, epc, 1'b1));
      msk_q.push_back(mkmask(1'b1, 1'b1));
      exp_q.push_back('0);
      msk_q.push_back(mkmask(1'b0, 1'b0));
   endtask

   task automatic push_idle(input int n);
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('0);
         msk_q.push_back(mkmask(1'b0, 1'b0));
      end
   endtask

   task automatic clear_stim();
      InstValid = 1'b0; IllInst = 1'b0; Overflow = 1'b0; Eret = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; ExtIrq = 1'b1; clear_stim(); ExcPc = 32'h0; StatusData = 32'h1;
      EpcData = 32'h0; MtcWe = 1'b1; MtcAddr = 5'd9; MtcData = 32'hdead_beef;
      repeat (3) @(negedge clk);
      checks++;
      if (obs !== 76'd0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", obs);
      end
      rst = 1'b1; ExtIrq = 1'b0; MtcWe = 1'b0; MtcAddr = 5'd0; MtcData = 32'd0;
      repeat (S + 1) @(negedge clk);
      checks++;
      if (obs !== 76'd0) begin
         errors++; $display("FAIL reset_idle: got %h expected 0", obs);
      end
   endtask

   task automatic test_illegal();
      StatusData = 32'h1;
      @(negedge clk);
      InstValid = 1'b1; IllInst = 1'b1; ExcPc = 32'h100;
      push_exc(2'b10, 32'h100, 1'b0);
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         e = exp_q.pop_front(); m = msk_q.pop_front(); checks++;
         if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL illegal T+%0d: got %h expected %h mask %h", c, obs, e, m);
         end
         clear_stim();
      end
   endtask

   task automatic test_priority();
      for (int sc = 0; sc < 2; sc++) begin
         @(negedge clk);
         InstValid = 1'b1; IllInst = (sc == 0); Overflow = 1'b1; ExcPc = 32'h140 + 32'(sc * 4);
         push_exc((sc == 0) ? 2'b10 : 2'b11, ExcPc, 1'b0);
         for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); m = msk_q.pop_front(); checks++;
            if ((obs & m) !== (e & m)) begin
               errors++; $display("FAIL priority%0d T+%0d: got %h expected %h mask %h", sc, c, obs, e, m);
            end
            clear_stim();
         end
      end
   endtask

   task automatic test_ext_irq();
      logic [31:0] st_tab [3];
      st_tab[0] = 32'h1; st_tab[1] = 32'h3; st_tab[2] = 32'h0;
      for (int sc = 0; sc < 3; sc++) begin
         @(negedge clk);
         StatusData = st_tab[sc]; ExtIrq = 1'b1; InstValid = 1'b1; ExcPc = 32'h180;
         push_idle(S);
         if (sc == 0) push_exc(2'b01, 32'h180, 1'b0);
         else         push_idle(8);
         for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); m = msk_q.pop_front(); checks++;
            if ((obs & m) !== (e & m)) begin
               errors++; $display("FAIL ext_irq st=%0h T+%0d: got %h expected %h mask %h", StatusData, c, obs, e, m);
            end
            if (exp_q.size() <= F + 2) begin
               InstValid = 1'b0; ExtIrq = 1'b0;
            end
         end
      end
      repeat (S + 1) @(negedge clk);
      StatusData = 32'h1;
   endtask

   task automatic test_nested();
      @(negedge clk);
      StatusData = 32'h3; InstValid = 1'b1; Overflow = 1'b1; ExcPc = 32'h300;
      push_exc(2'b11, 32'h300, 1'b1);
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         e = exp_q.pop_front(); m = msk_q.pop_front(); checks++;
         if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL nested T+%0d: got %h expected %h mask %h", c, obs, e, m);
         end
         clear_stim();
      end
      StatusData = 32'h1;
   endtask

   task automatic test_eret();
      for (int sc = 0; sc < 2; sc++) begin
         @(negedge clk);
         StatusData = (sc == 0) ? 32'h3 : 32'h1; EpcData = 32'h200;
         InstValid = 1'b1; Eret = 1'b1; Overflow = (sc == 1); ExcPc = 32'h220;
         if (sc == 0) push_eret(32'h3, 32'h200);
         else         push_exc(2'b11, 32'h220, 1'b0);
         for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); m = msk_q.pop_front(); checks++;
            if ((obs & m) !== (e & m)) begin
               errors++; $display("FAIL eret%0d T+%0d: got %h expected %h mask %h", sc, c, obs, e, m);
            end
            clear_stim();
         end
      end
      StatusData = 32'h1;
   endtask

   task automatic test_mtc_flush();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         MtcWe = k[0]; MtcAddr = 5'($urandom); MtcData = $urandom;
         @(negedge clk);
         e = mk(2'b00, MtcWe, MtcAddr, MtcData, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
         m = mkmask(MtcWe, 1'b0); checks++;
         if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL mtc_bypass%0d: got %h expected %h", k, obs, e);
         end
      end
      MtcWe = 1'b0;
      @(negedge clk);
      InstValid = 1'b1; IllInst = 1'b1; ExcPc = 32'h400; MtcWe = 1'b1; MtcAddr = 5'd14;
      push_exc(2'b10, 32'h400, 1'b0);
      for (int c = 1; exp_q.size() > 0; c++) begin
         @(negedge clk);
         e = exp_q.pop_front(); m = msk_q.pop_front(); checks++;
         if ((obs & m) !== (e & m)) begin
            errors++; $display("FAIL mtc_flush T+%0d: got %h expected %h mask %h", c, obs, e, m);
         end
         clear_stim();
         MtcWe = (exp_q.size() > 1); MtcAddr = 5'($urandom); MtcData = $urandom;
      end
      MtcWe = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      InstValid = 1'b1; Overflow = 1'b1; ExcPc = 32'h500;
      @(negedge clk);
      clear_stim();
      repeat (2) @(negedge clk);
      MtcWe = 1'b1; MtcAddr = 5'd3; MtcData = 32'h1234;
      rst = 1'b0;
      #1;
      checks++;
      if (obs !== 76'd0) begin
         errors++; $display("FAIL reset_mid_async: got %h expected 0", obs);
      end
      @(negedge clk);
      checks++;
      if (obs !== 76'd0) begin
         errors++; $display("FAIL reset_mid_hold: got %h expected 0", obs);
      end
      rst = 1'b1; MtcWe = 1'b0;
      @(negedge clk);
      m = mkmask(1'b0, 1'b0); checks++;
      if ((obs & m) !== 76'd0) begin
         errors++; $display("FAIL reset_mid_idle: got %h expected idle", obs);
      end
   endtask

   task automatic test_random();
      logic v, ill, ovf, er, ext;
      logic [31:0] st, pc;
      for (int it = 0; it < 40; it++) begin
         @(negedge clk);
         ext = 1'($urandom); ExtIrq = ext; st = {30'd0, 2'($urandom)}; StatusData = st;
         EpcData = $urandom; MtcWe = 1'($urandom); MtcAddr = 5'($urandom); MtcData = $urandom;
         for (int k = 0; k <= S; k++) begin
            @(negedge clk);
            e = mk(2'b00, MtcWe, MtcAddr, MtcData, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
            m = mkmask(MtcWe, 1'b0); checks++;
            if ((obs & m) !== (e & m)) begin
               errors++; $display("FAIL rand%0d idle%0d: got %h expected %h", it, k, obs, e);
            end
         end
         MtcWe = 1'b0;
         v = ($urandom_range(0, 3) != 0); ill = ($urandom_range(0, 3) == 0);
         ovf = ($urandom_range(0, 2) == 0); er = 1'($urandom); pc = $urandom & 32'hffff_fffc;
         InstValid = v; IllInst = ill; Overflow = ovf; Eret = er; ExcPc = pc;
         if (v && ill)                      push_exc(2'b10, pc, st[1]);
         else if (v && ovf)                 push_exc(2'b11, pc, st[1]);
         else if (v && ext && st[0] && !st[1]) push_exc(2'b01, pc, st[1]);
         else if (v && er)                  push_eret(st, EpcData);
         else                               push_idle(1);
         for (int c = 1; exp_q.size() > 0; c++) begin
            @(negedge clk);
            e = exp_q.pop_front(); m = msk_q.pop_front(); checks++;
            if ((obs & m) !== (e & m)) begin
               errors++; $display("FAIL rand%0d T+%0d: got %h expected %h mask %h", it, c, obs, e, m);
            end
            clear_stim();
         end
      end
      ExtIrq = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_illegal();
      test_priority();
      test_ext_irq();
      test_nested();
      test_eret();
      test_mtc_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Exception/interrupt sequencer in front of the CP0 register block.
- Prioritises exception sources, drives CP0's 2-bit Interrupt code for exactly one cycle, and writes EPC.
- Flushes and stalls the pipeline, then redirects the PC to the handler vector; handles ERET.
- Arbitrates the single CP0 write port between pipeline MTC0 traffic and its own EPC/Status writes.

Parameters:
- FLUSH_CYCLES, 2, pipeline drain cycles (Flush asserted), legal range 1..15
- SYNC_STAGES, 2, synchroniser depth for ExtIrq, legal range 2..3

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- ExtIrq  in  1  external device interrupt, level, asynchronous
- IllInst  in  1  illegal instruction in execute stage, qualified by InstValid
- Overflow  in  1  arithmetic overflow in execute stage, qualified by InstValid
- Eret  in  1  ERET in execute stage, qualified by InstValid
- InstValid  in  1  execute-stage instruction valid
- ExcPc  in  32  PC of execute-stage instruction
- StatusData  in  32  current CP0 Status (bit0 IE, bit1 EXL)
- EpcData  in  32  current CP0 EPC
- InterruptPc  in  32  handler vector from CP0, valid while Interrupt != 0
- MtcWe  in  1  pipeline MTC0 write request
- MtcAddr  in  5  MTC0 register address
- MtcData  in  32  MTC0 write data
- Interrupt  out  2  to CP0: 00 none, 01 ext, 10 illegal inst, 11 overflow
- CpWe  out  1  CP0 RegWrite
- CpWAddr  out  5  CP0 RegWriteAddr
- CpWData  out  32  CP0 RegWriteData
- Flush  out  1  kill in-flight pipeline instructions
- Stall  out  1  freeze PC/pipeline advance
- PcRedirect  out  1  load RedirectPc into PC this cycle
- RedirectPc  out  32  redirect target
- Busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, synchroniser flops 0, captured code/PC/vector 0; all outputs 0.
- ExtIrq passes SYNC_STAGES flops; extSync denotes the synchronised level.
- IDLE:
  - CP0 write port passes MTC0 through combinationally: CpWe=MtcWe, CpWAddr=MtcAddr, CpWData=MtcData.
  - Other outputs 0.
  - Evaluated each edge, priority high to low:
    1. InstValid&IllInst -> code 10
    2. InstValid&Overflow -> code 11
    3. InstValid&extSync&IE&!EXL -> code 01
    4. InstValid&Eret -> ERET
  - On 1-3: capture code, ExcPc and keepEpc=EXL; go to LATCH.
  - Exception beats ERET in the same cycle; the ERET is dropped.
  - ExtIrq is never taken without InstValid; it waits.
- LATCH (1 cycle):
  - Interrupt=code; Stall=1; CpWe=0; capture InterruptPc.
  - Go to FLUSH with counter=0.
- FLUSH (FLUSH_CYCLES cycles):
  - Stall=1, Flush=1.
  - Counter 0 only: CpWe=!keepEpc, CpWAddr=14, CpWData=captured ExcPc. A nested exception (EXL=1) keeps the old EPC.
  - MTC0 requests in all non-IDLE states are dropped, not queued.
  - When counter==FLUSH_CYCLES-1, go to REDIRECT.
- REDIRECT (1 cycle): PcRedirect=1, RedirectPc=captured vector, Stall=0, Flush=0; go to IDLE.
- ERET (1 cycle):
  - CpWe=1, CpWAddr=12, CpWData=StatusData & ~32'h2 (clear EXL).
  - PcRedirect=1, RedirectPc=EpcData, Flush=1; go to IDLE.
- Inputs in non-IDLE states:
  - Exception/Eret inputs ignored; flushed instructions re-raise their exceptions if re-fetched.
  - A still-high ExtIrq is re-evaluated in IDLE and is blocked by EXL=1.
- Latency: synchronous exception at edge T gives:
  - Interrupt in cycle T+1
  - EPC write in T+2
  - Flush T+2..T+1+FLUSH_CYCLES
  - PcRedirect T+2+FLUSH_CYCLES
- Interrupt is nonzero for exactly one cycle per exception and never in the same cycle as CpWe=1. CP0 ignores writes during an interrupt cycle.
- Reset mid-sequence: immediate return to IDLE, all outputs 0, no EPC write.
- Busy=1 in every state except IDLE.

Test Plan:
- Reset, then IllInst=1, InstValid=1, ExcPc=0x100 at T -> Interrupt=10 at T+1; CpWe/addr14/data 0x100 at T+2; Flush T+2..T+3; PcRedirect with RedirectPc=0x4 at T+4; Busy low at T+5.
- IllInst and Overflow together -> code 10 only. Overflow alone -> code 11, RedirectPc=0x10.
- ExtIrq=1 with Status=0x1 -> code 01 after the sync delay, RedirectPc=0x18. With Status=0x3 or 0x0 -> never taken, Busy stays 0.
- Status EXL=1 and Overflow -> Interrupt=11, CpWe stays 0 in the FLUSH cycles, EPC unchanged.
- Eret with EpcData=0x200 and Status=0x3 -> next cycle CpWe addr12 data 0x1, PcRedirect to 0x200. Eret plus Overflow in the same cycle -> exception sequence only.
- MtcWe during FLUSH -> CpWe=0 for the MTC0 address. Drive rst low during FLUSH -> all outputs 0 asynchronously, state IDLE.
